// File: rtl/limber_sram_ctrl_if.sv
// limber_sram_ctrl_if: command/response channel bundle for limber_sram_ctrl.
interface limber_sram_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 16,
  parameter int MW = 2
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  modport master(
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave(
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/limber_sram_ctrl.sv
// limber_sram_ctrl: valid/ready bus to single-port RAM strobes with in-order responses.
// Define LIMBER_SRAM_CTRL_RSP_FIFO_EN to add a 3-entry response FIFO that decouples cmd_ready from rsp_ready.
module limber_sram_ctrl #(
  parameter int AW     = 32,
  parameter int DW     = 16,
  parameter int MW     = 2,
  parameter int RAM_AW = 10,
  parameter int DP     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  limber_sram_ctrl_if.slave bus,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [MW-1:0]     ram_wem,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout
);
  localparam int ADDR_LSB = $clog2(MW);
  logic [AW-1:0] word;
  logic          in_range;
  logic          acc;
  logic          s1_vld;
  logic          s1_read;
  logic          s1_err;
  logic [DW-1:0] s1_rdata;
  assign word     = bus.cmd_addr >> ADDR_LSB;
  assign in_range = word < AW'(DP);
  assign acc      = bus.cmd_valid & bus.cmd_ready;
  // rst_n gate keeps the RAM quiet while reset holds cmd_ready high
  assign ram_cs   = acc & in_range & rst_n;
  assign ram_we   = ~bus.cmd_read;
  assign ram_wem  = bus.cmd_read ? '0 : bus.cmd_wmask;
  assign ram_addr = bus.cmd_addr[ADDR_LSB +: RAM_AW];
  assign ram_din  = bus.cmd_wdata;
  assign s1_rdata = (s1_read & ~s1_err) ? ram_dout : '0;
`ifdef LIMBER_SRAM_CTRL_RSP_FIFO_EN
  logic [DW:0] fifo_mem [3];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [1:0]  cnt;
  logic        pop;
  assign pop = bus.rsp_valid & bus.rsp_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_read <= 1'b0;
      s1_err  <= 1'b0;
    end else begin
      s1_vld <= acc;
      if (acc) begin
        s1_read <= bus.cmd_read;
        s1_err  <= ~in_range;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (s1_vld) fifo_mem[wr_ptr] <= {s1_rdata, s1_err};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      cnt    <= 2'd0;
    end else begin
      if (s1_vld) wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
      if (pop) rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
      cnt <= cnt + {1'b0, s1_vld} - {1'b0, pop};
    end
  end
  // s1 is counted too: its entry lands in the FIFO on the next clock regardless of rsp_ready
  assign bus.cmd_ready = ({1'b0, cnt} + {2'b0, s1_vld}) < 3'd3;
  assign bus.rsp_valid = cnt != 2'd0;
  assign {bus.rsp_rdata, bus.rsp_err} = bus.rsp_valid ? fifo_mem[rd_ptr] : '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_read <= 1'b0;
      s1_err  <= 1'b0;
    end else if (acc) begin
      s1_vld  <= 1'b1;
      s1_read <= bus.cmd_read;
      s1_err  <= ~in_range;
    end else if (bus.rsp_ready) begin
      s1_vld <= 1'b0;
    end
  end
  assign bus.cmd_ready = ~s1_vld | bus.rsp_ready;
  assign bus.rsp_valid = s1_vld;
  assign bus.rsp_rdata = s1_vld ? s1_rdata : '0;
  assign bus.rsp_err   = s1_err;
`endif
endmodule

// File: tb/tb_limber_sram_ctrl.sv
// tb_limber_sram_ctrl: vector table, directed corner sequences and random traffic against a transaction-level model.
module tb_limber_sram_ctrl;
  localparam int DP = 1024;
`ifdef LIMBER_SRAM_CTRL_RSP_FIFO_EN
  localparam int LAT  = 2;
  localparam int NACC = 3;
`else
  localparam int LAT  = 1;
  localparam int NACC = 1;
`endif
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_cs;
  logic        ram_we;
  logic [1:0]  ram_wem;
  logic [9:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout = 16'h0;
  logic [15:0] ram_mem [DP];
  logic [15:0] ref_mem [DP];
  typedef struct {logic [15:0] rdata; logic err;} rsp_t;
  typedef struct {logic rd; logic [31:0] addr; logic [15:0] wd; logic [1:0] wm; logic [15:0] exp_rdata; logic exp_err;} vec_t;
  rsp_t q[$];
  vec_t tbl[13];
  int checks = 0;
  int errors = 0;
  limber_sram_ctrl_if #(.AW(32), .DW(16), .MW(2)) bus();
  limber_sram_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 2; b++) if (ram_wem[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= ram_mem[ram_addr];
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge rst_n) q.delete();
  always @(negedge clk) begin
    logic [31:0] w;
    rsp_t e;
    if (rst_n) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("sb_rdata", bus.rsp_rdata, e.rdata);
          chk("sb_err", bus.rsp_err, e.err);
        end
      end
      w = bus.cmd_addr >> 1;
      chk("ram_cs", ram_cs, bus.cmd_valid && bus.cmd_ready && w < DP);
      if (ram_cs) begin
        chk("ram_addr", ram_addr, w[9:0]);
        chk("ram_we", ram_we, !bus.cmd_read);
        if (!bus.cmd_read) chk("ram_wem", ram_wem, bus.cmd_wmask);
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (w >= DP) q.push_back('{16'h0, 1'b1});
        else if (bus.cmd_read) q.push_back('{ref_mem[w], 1'b0});
        else begin
          for (int b = 0; b < 2; b++) if (bus.cmd_wmask[b]) ref_mem[w][8*b +: 8] = bus.cmd_wdata[8*b +: 8];
          q.push_back('{16'h0, 1'b0});
        end
      end
    end
  end
  task automatic do_cmd(input logic rd, input logic [31:0] a, input logic [15:0] wd, input logic [1:0] wm,
                        output logic [15:0] rdata, output logic err, output int lat);
    int n;
    bus.cmd_valid = 1'b1; bus.cmd_read = rd; bus.cmd_addr = a; bus.cmd_wdata = wd; bus.cmd_wmask = wm;
    bus.rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 20) begin n++; @(negedge clk); end
    if (!bus.cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    lat = 99; rdata = 16'h0; err = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin rdata = bus.rsp_rdata; err = bus.rsp_err; lat = i; break; end
    end
    if (lat == 99) chk("rsp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask
  task automatic drain(input string name);
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 30 && q.size() != 0; i++) @(posedge clk);
    chk(name, q.size(), 32'd0);
    @(posedge clk); #1;
  endtask
  initial begin
    logic [15:0] rdata;
    logic        err;
    int          lat, n_acc;
    logic        vld [12];
    logic [15:0] dat [12];
    logic [15:0] b2b_exp [4];
    logic [15:0] exp16;
    for (int i = 0; i < DP; i++) begin ram_mem[i] = 16'h0; ref_mem[i] = 16'h0; end
    tbl[0]  = '{1'b0, 32'h10,       16'hA5C3, 2'b11, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 32'h10,       16'h0000, 2'b00, 16'hA5C3, 1'b0};
    tbl[2]  = '{1'b0, 32'h04,       16'hFFFF, 2'b11, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 32'h04,       16'h1200, 2'b10, 16'h0000, 1'b0};
    tbl[4]  = '{1'b1, 32'h04,       16'h0000, 2'b11, 16'h12FF, 1'b0};
    tbl[5]  = '{1'b1, 32'h800,      16'h0000, 2'b00, 16'h0000, 1'b1};
    tbl[6]  = '{1'b0, 32'h800,      16'hBEEF, 2'b11, 16'h0000, 1'b1};
    tbl[7]  = '{1'b0, 32'h7FE,      16'h5AA5, 2'b01, 16'h0000, 1'b0};
    tbl[8]  = '{1'b1, 32'h7FF,      16'h0000, 2'b00, 16'h00A5, 1'b0};
    tbl[9]  = '{1'b1, 32'h11,       16'h0000, 2'b00, 16'hA5C3, 1'b0};
    tbl[10] = '{1'b1, 32'hFFFF0010, 16'h0000, 2'b00, 16'h0000, 1'b1};
    tbl[11] = '{1'b0, 32'h10,       16'h1234, 2'b00, 16'h0000, 1'b0};
    tbl[12] = '{1'b1, 32'h10,       16'h0000, 2'b00, 16'hA5C3, 1'b0};
    rst_n = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_read = 1'b1; bus.cmd_addr = 32'h10; bus.cmd_wdata = 16'h0; bus.cmd_wmask = 2'b0;
    bus.rsp_ready = 1'b0;
    #12;
    chk("rst_rsp_valid", bus.rsp_valid, 32'd0);
    chk("rst_cmd_ready", bus.cmd_ready, 32'd1);
    chk("rst_rsp_err", bus.rsp_err, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_ram_cs", ram_cs, 32'd0);
    bus.cmd_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 13; i++) begin
      do_cmd(tbl[i].rd, tbl[i].addr, tbl[i].wd, tbl[i].wm, rdata, err, lat);
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), err, tbl[i].exp_err);
      chk($sformatf("vec%0d_lat", i), lat, LAT);
    end
    do_cmd(1'b0, 32'h0, 16'h1111, 2'b11, rdata, err, lat);
    do_cmd(1'b0, 32'h2, 16'h2222, 2'b11, rdata, err, lat);
    do_cmd(1'b0, 32'h6, 16'h6666, 2'b11, rdata, err, lat);
    b2b_exp[0] = 16'h1111; b2b_exp[1] = 16'h2222; b2b_exp[2] = 16'h12FF; b2b_exp[3] = 16'h6666;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin bus.cmd_valid = 1'b1; bus.cmd_read = 1'b1; bus.cmd_addr = 32'(2 * i); end
      else bus.cmd_valid = 1'b0;
      @(negedge clk);
      if (i < 4) chk("b2b_ready", bus.cmd_ready, 32'd1);
      vld[i] = bus.rsp_valid; dat[i] = bus.rsp_rdata;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_valid%0d", i), vld[i], (i >= LAT && i < LAT + 4));
      if (i >= LAT && i < LAT + 4) chk($sformatf("b2b_data%0d", i), dat[i], b2b_exp[i - LAT]);
    end
    drain("b2b_drain");
    bus.rsp_ready = 1'b0; bus.cmd_valid = 1'b1; bus.cmd_read = 1'b1; bus.cmd_addr = 32'h2;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) n_acc++;
      if (i >= 3) begin
        chk("stall_ready", bus.cmd_ready, 32'd0);
        chk("stall_ram_cs", ram_cs, 32'd0);
        chk("stall_valid", bus.rsp_valid, 32'd1);
        chk("stall_rdata", bus.rsp_rdata, 16'h2222);
      end
      @(posedge clk); #1;
    end
    chk("stall_accepts", n_acc, NACC);
    drain("stall_drain");
    for (int i = 0; i < 400; i++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_read  = 1'($urandom_range(0, 1));
      bus.cmd_addr  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(32'h800, 32'h8FF)) : 32'($urandom_range(0, 32'h3F));
      bus.cmd_wdata = 16'($urandom);
      bus.cmd_wmask = 2'($urandom_range(0, 3));
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    drain("rand_drain");
    exp16 = ref_mem[8];
    bus.cmd_valid = 1'b1; bus.cmd_read = 1'b1; bus.cmd_addr = 32'h10; bus.rsp_ready = 1'b0;
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    for (int k = 0; k < 5 && !bus.rsp_valid; k++) @(posedge clk);
    #2;
    chk("pre_rst_valid", bus.rsp_valid, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.rsp_valid, 32'd0);
    chk("async_rst_err", bus.rsp_err, 32'd0);
    chk("async_rst_rdata", bus.rsp_rdata, 32'd0);
    chk("async_rst_ram_cs", ram_cs, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", bus.cmd_ready, 32'd1);
    chk("post_rst_valid", bus.rsp_valid, 32'd0);
    @(posedge clk); #1;
    do_cmd(1'b1, 32'h10, 16'h0, 2'b0, rdata, err, lat);
    chk("post_rst_rdata", rdata, exp16);
    chk("post_rst_err", err, 32'd0);
    chk("post_rst_lat", lat, LAT);
    drain("final_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/limber_sram_ctrl.md
Name: limber_sram_ctrl

Overview:
- Bus-side controller that sits directly upstream of the single-port simulation/synthesis RAM (1-clk registered read, per-byte write mask).
- Converts a valid/ready command channel (byte address, read/write, byte mask) into RAM cs/we/wem/addr/din strobes.
- Returns one response per command on a valid/ready response channel, with read data taken from the RAM output.
- Flags accesses outside the RAM range as errors; these never touch the RAM.

Parameters:
- AW, 32, command byte-address width.
- DW, 16, data width; must equal RAM DW.
- MW, 2, byte-mask width; power of two, equals DW/8 rounded up.
- RAM_AW, 10, RAM word-address width.
- DP, 1024, RAM depth in words; DP <= 2**RAM_AW.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_read  in  1  1 = read, 0 = write.
- cmd_addr  in  AW  byte address; word index = cmd_addr[ADDR_LSB +: RAM_AW], ADDR_LSB = log2(MW).
- cmd_wdata  in  DW  write data.
- cmd_wmask  in  MW  byte enables for writes; ignored for reads.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted when rsp_valid & rsp_ready.
- rsp_rdata  out  DW  read data; 0 for writes and errors.
- rsp_err  out  1  address out of range.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_wem  out  MW  RAM byte write mask.
- ram_addr  out  RAM_AW  RAM word address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data, valid 1 clk after a read strobe and held until the next read.

Behaviour:
- Address range:
  - in_range = (cmd_addr >> ADDR_LSB) < DP.
  - Low ADDR_LSB address bits are ignored; there is no misalignment error.
- RAM strobes are combinational from the command channel:
  - ram_cs = cmd_valid & cmd_ready & in_range.
  - ram_we = ~cmd_read.
  - ram_wem = cmd_wmask when writing, else 0.
  - ram_addr = word index; ram_din = cmd_wdata.
- Stage-1 register, set on each accepted command:
  - s1_vld <= 1 on accept; cleared when the stage drains with no new accept.
  - Also captures s1_read and s1_err = ~in_range.
- Default build (no macro):
  - rsp_valid = s1_vld; latency is 1 clk from accept to rsp_valid.
  - rsp_rdata = (s1_read & ~s1_err) ? ram_dout : 0.
  - rsp_err = s1_err.
  - cmd_ready = ~s1_vld | rsp_ready. Throughput is 1 command/clk when rsp_ready=1.
  - Under response stall, cmd_ready=0, so ram_cs=0 and the RAM's registered address holds. ram_dout, and therefore rsp_rdata, stays stable until the handshake.
  - Response handshake and new accept in the same cycle: s1 is overwritten with the new command and s1_vld stays 1.
- Write responses carry rdata=0, err=0 (in range). Out-of-range reads and writes carry rdata=0, err=1.
- Responses return strictly in command order; no reordering, no outstanding-ID tracking.
- rsp_rdata, rsp_err and ram_* must not depend on rsp_ready except through cmd_ready.
- Reset, asserted at any time including mid-transaction:
  - s1_vld=0, rsp_valid=0, cmd_ready=1 (default build), rsp_err=0, rsp_rdata=0, ram_cs=0.
  - An in-flight response is dropped.
  - A RAM write strobed in the same cycle reset asserts is not guaranteed.

Optional Feature:
- Macro LIMBER_SRAM_CTRL_RSP_FIFO_EN.
- When defined, a 3-entry response FIFO is inserted after stage 1 to break the rsp_ready -> cmd_ready combinational path:
  - Stage 1 pushes {rdata, err} into the FIFO on the clk after accept.
  - rsp_valid = fifo_count != 0; rsp_* come from the FIFO head register.
  - Accept-to-rsp_valid latency is 2 clk.
  - cmd_ready = (fifo_count + s1_vld) < 3, registered-only terms. Sustains 1 cmd/clk with rsp_ready=1.
  - Pointers wrap modulo 3; simultaneous push and pop leaves the count unchanged.
  - Reset empties the FIFO.
- When undefined, behaviour is exactly the default build above.

Test Plan:
- Write 0xA5C3 mask 2'b11 at addr 0x10, then read 0x10 -> ram_addr=8; read response rdata=0xA5C3, err=0, 1 clk after accept (2 clk with FIFO).
- Write 0xFFFF at 0x04, then write 0x1200 mask 2'b10, then read 0x04 -> rdata=0x12FF.
- Read addr 0x800 (word 1024 >= DP) -> ram_cs never asserted; response rdata=0, err=1.
- Back-to-back reads 0x0, 0x2, 0x4, 0x6 with rsp_ready=1 -> cmd_ready held 1; 4 responses on 4 consecutive clks, in order.
- Read 0x2, hold rsp_ready=0 for 5 clks -> cmd_ready=0, rsp_rdata stable all 5 clks, no ram_cs; releases on the handshake. With FIFO: 3 commands accepted, then cmd_ready=0.
- Assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately (async); after release, cmd_ready=1, and the next read returns correct RAM contents.
